// File: rtl/clock_set_ctrl_if.sv
// Bus bundle for the clock set/alarm controller.
// The master side is the timebase/counter/buttons environment, the slave side is the controller.
interface clock_set_ctrl_if;
    logic       tick_1s;
    logic       btn_mode;
    logic       btn_inc;
    logic       alarm_en;
    logic [7:0] cur_hr;
    logic [7:0] cur_min;
    logic       cur_sec_zero;
    logic       run_en;
    logic       load;
    logic [7:0] ld_hr;
    logic [7:0] ld_min;
    logic [7:0] disp_hr;
    logic [7:0] disp_min;
    logic       blank_hr;
    logic       blank_min;
    logic [2:0] mode;
    logic       alarm_led;

    modport master (
        output tick_1s, btn_mode, btn_inc, alarm_en,
        output cur_hr, cur_min, cur_sec_zero,
        input  run_en, load, ld_hr, ld_min,
        input  disp_hr, disp_min, blank_hr, blank_min,
        input  mode, alarm_led
    );

    modport slave (
        input  tick_1s, btn_mode, btn_inc, alarm_en,
        input  cur_hr, cur_min, cur_sec_zero,
        output run_en, load, ld_hr, ld_min,
        output disp_hr, disp_min, blank_hr, blank_min,
        output mode, alarm_led
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set / alarm-set mode controller for a BCD wall clock.
// Handles button edge detect, edit/alarm registers, blink and alarm ringing.
module clock_set_ctrl #(
    parameter int ALARM_SECS = 60
) (
    input logic             CLOCK_50,
    input logic             KEY0,
    clock_set_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        AL_HR   = 3'd3,
        AL_MIN  = 3'd4
    } state_e;

    localparam int CW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);
    localparam logic [CW-1:0] RING_LOAD = CW'(ALARM_SECS);
    localparam bit RING_ON = (ALARM_SECS != 0);

    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_e        state_q, state_d;
    logic          mode_q, inc_q;
    logic [7:0]    edit_hr_q, edit_hr_d;
    logic [7:0]    edit_min_q, edit_min_d;
    logic [7:0]    alarm_hr_q, alarm_hr_d;
    logic [7:0]    alarm_min_q, alarm_min_d;
    logic [7:0]    disp_hr_q, disp_hr_d;
    logic [7:0]    disp_min_q, disp_min_d;
    logic          load_q, load_d;
    logic          blink_q, blink_d;
    logic          ring_q, ring_d;
    logic [CW-1:0] ring_cnt_q, ring_cnt_d;

    logic mode_p;
    logic inc_raw;
    logic inc_p;
    logic ring_stop;
    logic ring_start;
    logic in_run;

    // A mode press always wins; the coincident inc press is dropped.
    assign mode_p  = bus.btn_mode & ~mode_q;
    assign inc_raw = bus.btn_inc & ~inc_q;
    assign inc_p   = inc_raw & ~mode_p;
    assign in_run  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mode_p) state_d = SET_HR;
            SET_HR:  if (mode_p) state_d = SET_MIN;
            SET_MIN: if (mode_p) state_d = AL_HR;
            AL_HR:   if (mode_p) state_d = AL_MIN;
            AL_MIN:  if (mode_p) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        edit_hr_d   = edit_hr_q;
        edit_min_d  = edit_min_q;
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        if (in_run && mode_p) begin
            edit_hr_d  = bus.cur_hr;
            edit_min_d = bus.cur_min;
        end
        if (inc_p) begin
            unique case (state_q)
                SET_HR:  edit_hr_d   = hr_inc(edit_hr_q);
                SET_MIN: edit_min_d  = min_inc(edit_min_q);
                AL_HR:   alarm_hr_d  = hr_inc(alarm_hr_q);
                AL_MIN:  alarm_min_d = min_inc(alarm_min_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        disp_hr_d  = alarm_hr_q;
        disp_min_d = alarm_min_q;
        unique case (state_q)
            RUN: begin
                disp_hr_d  = bus.cur_hr;
                disp_min_d = bus.cur_min;
            end
            SET_HR, SET_MIN: begin
                disp_hr_d  = edit_hr_q;
                disp_min_d = edit_min_q;
            end
            default: ;
        endcase
    end

    assign load_d  = (state_q == SET_MIN) && mode_p;
    assign blink_d = (state_d != state_q) ? 1'b0 : (blink_q ^ bus.tick_1s);

    // Leaving RUN is seen through state_d so the ring is cut on the same edge.
    assign ring_stop = ~bus.alarm_en
                     | (state_d != RUN)
                     | (in_run & inc_raw);

    assign ring_start = in_run
                      && (state_d == RUN)
                      && bus.alarm_en
                      && bus.tick_1s
                      && bus.cur_sec_zero
                      && (bus.cur_hr == alarm_hr_q)
                      && (bus.cur_min == alarm_min_q);

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_q) begin
            if (ring_stop) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else if (bus.tick_1s) begin
                if (ring_cnt_q <= CW'(1)) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q - CW'(1);
                end
            end
        end else if (ring_start && RING_ON) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q     <= RUN;
            mode_q      <= 1'b0;
            inc_q       <= 1'b0;
            edit_hr_q   <= 8'h00;
            edit_min_q  <= 8'h00;
            alarm_hr_q  <= 8'h06;
            alarm_min_q <= 8'h30;
            disp_hr_q   <= 8'h00;
            disp_min_q  <= 8'h00;
            load_q      <= 1'b0;
            blink_q     <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= bus.btn_mode;
            inc_q       <= bus.btn_inc;
            edit_hr_q   <= edit_hr_d;
            edit_min_q  <= edit_min_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            disp_hr_q   <= disp_hr_d;
            disp_min_q  <= disp_min_d;
            load_q      <= load_d;
            blink_q     <= blink_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

    assign bus.run_en    = (state_q != SET_HR) && (state_q != SET_MIN);
    assign bus.load      = load_q;
    assign bus.ld_hr     = edit_hr_q;
    assign bus.ld_min    = edit_min_q;
    assign bus.disp_hr   = disp_hr_q;
    assign bus.disp_min  = disp_min_q;
    assign bus.blank_hr  = blink_q && ((state_q == SET_HR) || (state_q == AL_HR));
    assign bus.blank_min = blink_q && ((state_q == SET_MIN) || (state_q == AL_MIN));
    assign bus.mode      = state_q;
    assign bus.alarm_led = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomised and directed bench for clock_set_ctrl against a
// decimal-arithmetic reference model.
module tb_clock_set_ctrl;

    logic CLOCK_50 = 1'b0;
    logic KEY0     = 1'b0;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.ALARM_SECS(60)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    int c_hr  = 0;
    int c_min = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    assign bus.cur_hr  = to_bcd(c_hr);
    assign bus.cur_min = to_bcd(c_min);

    // Reference model state, kept as plain decimal integers.
    int m_st, m_ehr, m_emin, m_ahr, m_amin, m_cnt;
    int m_dh, m_dm, m_ldh, m_ldm;
    bit m_ring, m_blink, m_load, p_mode, p_inc;

    int n_loads = 0;
    logic [7:0] seen_ldh, seen_ldm;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ehr = 0; m_emin = 0; m_ahr = 6; m_amin = 30;
        m_cnt = 0; m_ring = 0; m_blink = 0; m_load = 0;
        m_dh = 0; m_dm = 0; m_ldh = 0; m_ldm = 0;
        p_mode = 0; p_inc = 0;
    endtask

    task automatic model_step();
        bit mp, iraw, ip, stop;
        int ns;
        mp   = bus.btn_mode && !p_mode;
        iraw = bus.btn_inc && !p_inc;
        ip   = iraw && !mp;
        ns   = mp ? (m_st + 1) % 5 : m_st;
        m_load = (m_st == 2) && mp;
        m_ldh  = m_ehr;
        m_ldm  = m_emin;
        case (m_st)
            0: begin m_dh = c_hr; m_dm = c_min; end
            1, 2: begin m_dh = m_ehr; m_dm = m_emin; end
            default: begin m_dh = m_ahr; m_dm = m_amin; end
        endcase
        stop = !bus.alarm_en || (ns != 0) || (m_st == 0 && iraw);
        if (m_ring) begin
            if (stop) begin
                m_ring = 0; m_cnt = 0;
            end else if (bus.tick_1s) begin
                m_cnt--;
                if (m_cnt == 0) m_ring = 0;
            end
        end else if (m_st == 0 && ns == 0 && bus.alarm_en && bus.tick_1s
                     && bus.cur_sec_zero && c_hr == m_ahr && c_min == m_amin) begin
            m_ring = 1; m_cnt = 60;
        end
        m_blink = (ns != m_st) ? 1'b0 : (m_blink ^ bus.tick_1s);
        if (m_st == 0 && mp) begin
            m_ehr = c_hr; m_emin = c_min;
        end
        if (ip) begin
            case (m_st)
                1: m_ehr  = (m_ehr + 1) % 24;
                2: m_emin = (m_emin + 1) % 60;
                3: m_ahr  = (m_ahr + 1) % 24;
                4: m_amin = (m_amin + 1) % 60;
                default: ;
            endcase
        end
        m_st   = ns;
        p_mode = bus.btn_mode;
        p_inc  = bus.btn_inc;
    endtask

    task automatic compare_all();
        check("mode", 32'(bus.mode), 32'(m_st));
        check("run_en", 32'(bus.run_en), 32'(m_st != 1 && m_st != 2));
        check("load", 32'(bus.load), 32'(m_load));
        if (m_load) begin
            check("ld_hr", 32'(bus.ld_hr), 32'(to_bcd(m_ldh)));
            check("ld_min", 32'(bus.ld_min), 32'(to_bcd(m_ldm)));
        end
        if (bus.load === 1'b1) begin
            n_loads++;
            seen_ldh = bus.ld_hr;
            seen_ldm = bus.ld_min;
        end
        check("disp_hr", 32'(bus.disp_hr), 32'(to_bcd(m_dh)));
        check("disp_min", 32'(bus.disp_min), 32'(to_bcd(m_dm)));
        check("blank_hr", 32'(bus.blank_hr),
              32'(m_blink && (m_st == 1 || m_st == 3)));
        check("blank_min", 32'(bus.blank_min),
              32'(m_blink && (m_st == 2 || m_st == 4)));
        check("alarm_led", 32'(bus.alarm_led), 32'(m_ring));
    endtask

    task automatic step();
        model_step();
        @(posedge CLOCK_50);
        #1;
        compare_all();
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1; step();
        bus.btn_mode = 1'b0; step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1; step();
            bus.btn_inc = 1'b0; step();
        end
    endtask

    task automatic ring_once();
        c_hr = m_ahr; c_min = m_amin;
        bus.cur_sec_zero = 1'b1;
        bus.tick_1s = 1'b1; step();
        bus.tick_1s = 1'b0;
        bus.cur_sec_zero = 1'b0;
        c_min = (c_min + 1) % 60;
        step();
    endtask

    initial begin
        int n;
        bus.tick_1s = 0; bus.btn_mode = 0; bus.btn_inc = 0;
        bus.alarm_en = 1; bus.cur_sec_zero = 0;
        seen_ldh = '0; seen_ldm = '0;
        model_reset();
        #1 compare_all();
        @(negedge CLOCK_50) KEY0 = 1'b1;

        // Set sequence from 12:34: hours wrap to 01, minutes to 04.
        c_hr = 12; c_min = 34;
        step();
        press_mode();
        press_inc(13);
        check("edit_hr_wrap", 32'(bus.disp_hr), 32'h01);
        press_mode();
        press_inc(30);
        check("edit_min_wrap", 32'(bus.disp_min), 32'h04);
        n_loads = 0;
        press_mode();
        step(); step();
        check("load_count", 32'(n_loads), 32'd1);
        check("ld_hr_seq", 32'(seen_ldh), 32'h01);
        check("ld_min_seq", 32'(seen_ldm), 32'h04);
        press_mode();
        press_mode();

        // Minute wrap 58 -> 59 -> 00, hours untouched.
        c_hr = 3; c_min = 58;
        step();
        press_mode();
        press_mode();
        press_inc(1);
        check("min_59", 32'(bus.disp_min), 32'h59);
        press_inc(1);
        check("min_00", 32'(bus.disp_min), 32'h00);
        check("hr_kept", 32'(bus.disp_hr), 32'h03);
        press_mode(); press_mode(); press_mode();

        // Alarm at 06:30 rings for exactly 60 ticks.
        bus.alarm_en = 1'b1;
        ring_once();
        check("ring_start", 32'(bus.alarm_led), 32'd1);
        n = 0;
        while (bus.alarm_led === 1'b1 && n < 100) begin
            bus.tick_1s = 1'b1; step();
            bus.tick_1s = 1'b0; step();
            n++;
        end
        check("ring_len", 32'(n), 32'd60);

        // Silence by inc, then by alarm_en falling.
        ring_once();
        bus.btn_inc = 1'b1; step();
        check("silence_inc", 32'(bus.alarm_led), 32'd0);
        bus.btn_inc = 1'b0; step();
        ring_once();
        bus.alarm_en = 1'b0; step();
        check("silence_en", 32'(bus.alarm_led), 32'd0);
        bus.alarm_en = 1'b1; step();

        // Collision and held button.
        c_hr = 6; c_min = 31;
        press_mode();
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; step();
        check("collide_mode", 32'(bus.mode), 32'd2);
        for (int i = 0; i < 5; i++) step();
        check("collide_hr", 32'(bus.disp_hr), 32'h06);
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; step();
        bus.btn_inc = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.btn_inc = 1'b0; step();
        check("held_inc", 32'(bus.disp_min), 32'h32);

        // Asynchronous reset between edges while in SET_MIN.
        #2 KEY0 = 1'b0;
        model_reset();
        #1;
        check("arst_mode", 32'(bus.mode), 32'd0);
        check("arst_run_en", 32'(bus.run_en), 32'd1);
        check("arst_load", 32'(bus.load), 32'd0);
        compare_all();
        @(negedge CLOCK_50) KEY0 = 1'b1;
        press_mode(); press_mode(); press_mode();
        step();
        check("arst_alarm_hr", 32'(bus.disp_hr), 32'h06);
        check("arst_alarm_min", 32'(bus.disp_min), 32'h30);
        press_mode(); press_mode();

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.btn_mode = ~bus.btn_mode;
            if ($urandom_range(0, 5) == 0) bus.btn_inc = ~bus.btn_inc;
            bus.tick_1s = ($urandom_range(0, 3) == 0);
            bus.cur_sec_zero = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) bus.alarm_en = ~bus.alarm_en;
            if ($urandom_range(0, 2) == 0) begin
                c_hr = m_ahr; c_min = m_amin;
            end else if ($urandom_range(0, 3) == 0) begin
                c_hr = $urandom_range(0, 23);
                c_min = $urandom_range(0, 59);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter ALARM_SECS, default 60, is the number of tick_1s pulses the alarm rings before self-stopping.
REQ-002 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 KEY0  in  1  reset; one clock, asynchronous, active-low.
REQ-004 tick_1s  in  1  one-cycle pulse once per second from the timebase.
REQ-005 btn_mode  in  1  mode button; active-high level, already debounced.
REQ-006 btn_inc  in  1  increment/silence button; active-high level, already debounced.
REQ-007 alarm_en  in  1  switch; 1 = alarm armed.
REQ-008 cur_hr, cur_min  in  8 each  running time, packed BCD {tens,units}.
REQ-009 cur_sec_zero  in  1  high while the running seconds equal 00.
REQ-010 run_en  out  1  time counter advances only while 1.
REQ-011 load  out  1  one-cycle strobe; the counter takes ld_hr/ld_min and clears its seconds to 00.
REQ-012 ld_hr, ld_min  out  8 each  packed BCD load value, valid while load=1.
REQ-013 disp_hr, disp_min  out  8 each  packed BCD digits for the HEX decoders.
REQ-014 blank_hr, blank_min  out  1 each  1 = blank that digit pair (blink).
REQ-015 mode  out  3  current state encoding.
REQ-016 alarm_led  out  1  1 while the alarm rings.

Function
REQ-017 Each button is registered once; a press is a rising edge, giving exactly one internal pulse per press regardless of hold length.
REQ-018 States and encodings: RUN=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4; a mode press advances RUN->SET_HR->SET_MIN->AL_HR->AL_MIN->RUN; encodings 5-7 return to RUN on the next edge.
REQ-019 RUN->SET_HR copies cur_hr/cur_min into edit_hr/edit_min on the same edge.
REQ-020 run_en=0 in SET_HR and SET_MIN, 1 in all other states.
REQ-021 SET_MIN->AL_HR asserts load for exactly one cycle with ld_hr=edit_hr, ld_min=edit_min; load is 0 at all other times.
REQ-022 An inc pulse in SET_HR/AL_HR increments edit_hr/alarm_hr in BCD, 09->10, 19->20, 23->00.
REQ-023 An inc pulse in SET_MIN/AL_MIN increments edit_min/alarm_min in BCD, 09->10, 59->00; hours are never affected.
REQ-024 Mode and inc pulses on the same cycle: the mode pulse is taken and the inc pulse is discarded.
REQ-025 disp = cur in RUN, edit in SET_HR/SET_MIN, alarm in AL_HR/AL_MIN; registered, so it is valid one cycle after a state change.
REQ-026 blink_phase is cleared on every state change and toggles on each tick_1s; blank_hr = blink_phase in SET_HR/AL_HR, blank_min = blink_phase in SET_MIN/AL_MIN, otherwise both 0.
REQ-027 Ring start: in RUN with alarm_en=1, tick_1s=1, cur_sec_zero=1, cur_hr=alarm_hr and cur_min=alarm_min, alarm_led goes 1 and ring_cnt loads ALARM_SECS.
REQ-028 While ringing, each tick_1s decrements ring_cnt; reaching 0 clears alarm_led.
REQ-029 Ringing stops within one cycle on any of: inc pulse in RUN, alarm_en=0, leaving RUN.
REQ-030 An inc pulse in RUN when not ringing has no effect.
REQ-031 A ring-start condition while already ringing does not reload ring_cnt.

Reset
REQ-032 KEY0=0 immediately forces: state RUN, edit 00:00, alarm 06:30, ring_cnt 0, blink_phase 0, button history 0.
REQ-033 KEY0=0 immediately forces outputs: run_en=1, load=0, alarm_led=0, blanks=0, mode=0, disp=00:00.
REQ-034 Reset asserted mid-edit discards edit values with no load pulse; the first edge after release behaves as RUN.

Verification
REQ-035 Set sequence: cur=12:34, press mode, inc x13, mode, inc x30, mode -> edit_hr wraps to 01, edit_min to 04, single load with ld=01:04, run_en 0 during the two SET states only.
REQ-036 Minute wrap: SET_MIN with edit 58, two inc presses -> 59 then 00, edit_hr unchanged.
REQ-037 Alarm: alarm 06:30, alarm_en=1, present 06:30 with cur_sec_zero and tick_1s -> alarm_led=1; with no further input it clears after exactly 60 ticks.
REQ-038 Silence: while ringing press inc -> alarm_led=0 next cycle; repeat with alarm_en dropping to 0 -> same result.
REQ-039 Collision: btn_mode and btn_inc rising on the same cycle in SET_HR -> state SET_MIN, edit_hr unchanged; a held button produces only one increment.
REQ-040 Async reset: pull KEY0 low in SET_MIN between clock edges -> mode=0, run_en=1, load=0 before the next edge, alarm reads 06:30.
